bufz_bus_drive_ctrl: RTL and testbench

- Sequential controller that sits directly upstream of a bank of bufz tristate drivers.
- Accepts words over a valid/ready stream and obtains ownership of a shared tristate bus from an external arbiter.
- Generates the per-bit I data and the common EN enable that feed the drivers.
- Enforces turnaround dead cycles and post-burst hold cycles so that two drivers never overlap on the bus.

---
 rtl/bufz_bus_pkg.sv | 36 +++
 rtl/bufz_bus_dwncnt.sv | 38 +++
 rtl/bufz_bus_drive_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_bufz_bus_drive_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bufz_bus_pkg.sv
// -----------------------------------------------------------------------------
// bufz_bus_pkg
// Shared types and constants for the bufz bus drive controller.
//   state_t     : controller states (IDLE, REQ, TURN, DRIVE, HOLD, REL)
//   CNT_W       : width of the TURN/HOLD phase counter
//   TURN_MAX    : largest supported TURN_CYCLES value
//   HOLD_MAX    : largest supported HOLD_CYCLES value
//   phase_load(): value loaded into the phase counter for an N-cycle phase
// -----------------------------------------------------------------------------
package bufz_bus_pkg;

    localparam int CNT_W    = 4;
    localparam int TURN_MAX = 15;
    localparam int HOLD_MAX = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        TURN  = 3'd2,
        DRIVE = 3'd3,
        HOLD  = 3'd4,
        REL   = 3'd5
    } state_t;

    // The counter reaches zero on the last cycle of a phase, so an N-cycle
    // phase is loaded with N-1. Out-of-range requests are clamped.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles, input int lim);
        int c;
        c = (cycles > lim) ? lim : cycles;
        if (c <= 0) begin
            return '0;
        end
        return CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/bufz_bus_dwncnt.sv
// -----------------------------------------------------------------------------
// bufz_bus_dwncnt
// Loadable down-counter with zero flag, shared by the TURN and HOLD phases.
// Saturates at zero; never wraps.
// Ports:
//   clk      : rising-edge clock
//   rn       : synchronous active-low reset (clears the count)
//   load     : load load_val this cycle (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one unless already zero
//   cnt      : current count
//   zero     : cnt == 0
// -----------------------------------------------------------------------------
module bufz_bus_dwncnt
    import bufz_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bufz_bus_drive_ctrl.sv
// -----------------------------------------------------------------------------
// bufz_bus_drive_ctrl
// Controller feeding a bank of bufz tristate drivers. Takes words from a
// valid/ready stream, wins the shared bus from an external arbiter, and
// produces the per-bit data I plus the common enable EN, inserting turnaround
// dead cycles before driving and hold cycles after the last word.
//
// Stream handshake: a word transfers on every rising CLK edge where
// S_VALID && S_READY. S_READY is registered and only high in DRIVE; the
// upstream must hold S_DATA/S_LAST stable while S_VALID is high and not taken.
//
// Optional build macro BUFZ_BUS_DRIVE_CTRL_PARK_EN: when defined, I is forced
// to zero whenever EN is low; otherwise I keeps the last driven word.
//
// Ports:
//   CLK, RN              : clock, synchronous active-low reset
//   S_VALID/S_READY      : upstream word handshake
//   S_DATA, S_LAST       : upstream word and end-of-burst marker
//   BUS_REQ, BUS_GNT     : arbiter request / grant
//   EN, I                : enable and data to the bufz drivers
//   BUSY                 : high outside IDLE
//   dbg_state, dbg_abort : current state and sticky grant-loss flag
// -----------------------------------------------------------------------------
module bufz_bus_drive_ctrl
    import bufz_bus_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [WIDTH-1:0] S_DATA,
    input  logic             S_LAST,
    output logic             BUS_REQ,
    input  logic             BUS_GNT,
    output logic             EN,
    output logic [WIDTH-1:0] I,
    output logic             BUSY,
    output state_t           dbg_state,
    output logic             dbg_abort
);

    localparam bit               SKIP_TURN = (TURN_CYCLES <= 0);
    localparam bit               SKIP_HOLD = (HOLD_CYCLES <= 0);
    localparam logic [CNT_W-1:0] TURN_LOAD = phase_load(TURN_CYCLES, TURN_MAX);
    localparam logic [CNT_W-1:0] HOLD_LOAD = phase_load(HOLD_CYCLES, HOLD_MAX);

    state_t           state, state_nx;
    logic             en_q, en_nx;
    logic [WIDTH-1:0] i_q, i_nx;
    logic             req_q, req_nx;
    logic             rdy_q, rdy_nx;
    logic             busy_q, busy_nx;
    logic             abort_q, abort_nx;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt;
    logic             hs;

    // rdy_q is only ever high in DRIVE, so this is the DRIVE handshake.
    assign hs = S_VALID && rdy_q;

    bufz_bus_dwncnt u_cnt (
        .clk      (CLK),
        .rn       (RN),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx = state;
        en_nx    = en_q;
        i_nx     = i_q;
        abort_nx = abort_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        unique case (state)
            IDLE: begin
                en_nx = 1'b0;
                if (S_VALID) begin
                    state_nx = REQ;
                    abort_nx = 1'b0;
                end
            end
            REQ: begin
                en_nx = 1'b0;
                if (BUS_GNT) begin
                    if (SKIP_TURN) begin
                        state_nx = DRIVE;
                    end else begin
                        state_nx = TURN;
                        cnt_load = 1'b1;
                        cnt_val  = TURN_LOAD;
                    end
                end
            end
            TURN: begin
                en_nx = 1'b0;
                if (!BUS_GNT) begin
                    state_nx = REQ;
                end else if (cnt_zero) begin
                    state_nx = DRIVE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRIVE: begin
                // Grant loss wins over a same-cycle handshake: that word is dropped.
                if (!BUS_GNT) begin
                    state_nx = REL;
                    en_nx    = 1'b0;
                    abort_nx = 1'b1;
                end else if (hs) begin
                    en_nx = 1'b1;
                    i_nx  = S_DATA;
                    if (S_LAST) begin
                        if (SKIP_HOLD) begin
                            state_nx = REL;
                        end else begin
                            state_nx = HOLD;
                            cnt_load = 1'b1;
                            cnt_val  = HOLD_LOAD;
                        end
                    end
                end
            end
            HOLD: begin
                if (!BUS_GNT) begin
                    state_nx = REL;
                    en_nx    = 1'b0;
                    abort_nx = 1'b1;
                end else if (cnt_zero) begin
                    state_nx = REL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            REL: begin
                // The last word stays on the bus during REL; EN and BUS_REQ
                // drop together on entry to IDLE.
                en_nx    = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                en_nx    = 1'b0;
                state_nx = IDLE;
            end
        endcase

`ifdef BUFZ_BUS_DRIVE_CTRL_PARK_EN
        if (!en_nx) begin
            i_nx = '0;
        end
`else
        i_nx = i_nx;
`endif

        rdy_nx  = (state_nx == DRIVE);
        req_nx  = (state_nx != IDLE);
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            i_q     <= '0;
            req_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nx;
            en_q    <= en_nx;
            i_q     <= i_nx;
            req_q   <= req_nx;
            rdy_q   <= rdy_nx;
            busy_q  <= busy_nx;
            abort_q <= abort_nx;
        end
    end

    assign EN        = en_q;
    assign I         = i_q;
    assign BUS_REQ   = req_q;
    assign S_READY   = rdy_q;
    assign BUSY      = busy_q;
    assign dbg_state = state;
    assign dbg_abort = abort_q;

endmodule

// File: tb/tb_bufz_bus_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bufz_bus_drive_ctrl
// Two controllers share one stimulus: u1 with TURN=1/HOLD=1 and u0 with
// TURN=0/HOLD=0. A cycle reference model tracks each one; a vector table
// covers a full burst, directed sequences cover bubbles, grant loss, reset
// and the zero-length phases, then random traffic runs against the models.
// -----------------------------------------------------------------------------
module tb_bufz_bus_drive_ctrl;
    import bufz_bus_pkg::*;

`ifdef BUFZ_BUS_DRIVE_CTRL_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    // ---------------- clock / reset / stimulus signals ----------------
    logic       clk;
    logic       rn, vld, lst, gnt;
    logic [7:0] data;

    logic       rdy1, req1, en1, busy1, abort1;
    logic [7:0] i1;
    state_t     st1;
    logic       rdy0, req0, en0, busy0, abort0;
    logic [7:0] i0;
    state_t     st0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bufz_bus_drive_ctrl #(.WIDTH(8), .TURN_CYCLES(1), .HOLD_CYCLES(1)) u1 (
        .CLK(clk), .RN(rn), .S_VALID(vld), .S_READY(rdy1), .S_DATA(data),
        .S_LAST(lst), .BUS_REQ(req1), .BUS_GNT(gnt), .EN(en1), .I(i1),
        .BUSY(busy1), .dbg_state(st1), .dbg_abort(abort1)
    );

    bufz_bus_drive_ctrl #(.WIDTH(8), .TURN_CYCLES(0), .HOLD_CYCLES(0)) u0 (
        .CLK(clk), .RN(rn), .S_VALID(vld), .S_READY(rdy0), .S_DATA(data),
        .S_LAST(lst), .BUS_REQ(req0), .BUS_GNT(gnt), .EN(en0), .I(i0),
        .BUSY(busy0), .dbg_state(st0), .dbg_abort(abort0)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        state_t     st;
        logic [4:0] elapsed;   // cycles already spent in TURN or HOLD
        logic       en;
        logic [7:0] i;
        logic       abort;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t step(input mdl_t m, input int turn, input int hold,
                                  input logic r, input logic v, input logic [7:0] d,
                                  input logic l, input logic g);
        mdl_t n;
        n = m;
        if (!r) begin
            n = '{st: IDLE, elapsed: 5'd0, en: 1'b0, i: 8'h00, abort: 1'b0};
            return n;
        end
        case (m.st)
            IDLE: if (v) begin n.st = REQ; n.abort = 1'b0; end
            REQ: if (g) begin n.st = (turn == 0) ? DRIVE : TURN; n.elapsed = 5'd0; end
            TURN: begin
                if (!g) n.st = REQ;
                else begin
                    n.elapsed = m.elapsed + 5'd1;
                    if (int'(n.elapsed) >= turn) n.st = DRIVE;
                end
            end
            DRIVE: begin
                if (!g) begin n.st = REL; n.en = 1'b0; n.abort = 1'b1; end
                else if (v) begin
                    n.en = 1'b1;
                    n.i  = d;
                    if (l) begin n.st = (hold == 0) ? REL : HOLD; n.elapsed = 5'd0; end
                end
            end
            HOLD: begin
                if (!g) begin n.st = REL; n.en = 1'b0; n.abort = 1'b1; end
                else begin
                    n.elapsed = m.elapsed + 5'd1;
                    if (int'(n.elapsed) >= hold) n.st = REL;
                end
            end
            default: begin n.st = IDLE; n.en = 1'b0; end
        endcase
        if (PARK && !n.en) n.i = 8'h00;
        return n;
    endfunction

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic l, input logic g);
        rn = r; vld = v; data = d; lst = l; gnt = g;
    endtask

    task automatic tick();
        logic took;
        @(posedge clk);
        took = rn && gnt && vld && (m1.st == DRIVE);
        if (took) exp_q.push_back(data);
        m1 = step(m1, 1, 1, rn, vld, data, lst, gnt);
        m0 = step(m0, 0, 0, rn, vld, data, lst, gnt);
        #1;
        chk("u1_state", 32'(st1),  32'(m1.st));
        chk("u1_en",    32'(en1),  32'(m1.en));
        chk("u1_i",     32'(i1),   32'(m1.i));
        chk("u1_req",   32'(req1), 32'(m1.st != IDLE));
        chk("u1_rdy",   32'(rdy1), 32'(m1.st == DRIVE));
        chk("u1_busy",  32'(busy1), 32'(m1.st != IDLE));
        chk("u1_abort", 32'(abort1), 32'(m1.abort));
        chk("u0_state", 32'(st0),  32'(m0.st));
        chk("u0_en",    32'(en0),  32'(m0.en));
        chk("u0_i",     32'(i0),   32'(m0.i));
        chk("u0_req",   32'(req0), 32'(m0.st != IDLE));
        chk("u0_rdy",   32'(rdy0), 32'(m0.st == DRIVE));
        chk("u0_abort", 32'(abort0), 32'(m0.abort));
        if (took && exp_q.size() > 0) chk("u1_word_on_bus", 32'(i1), 32'(exp_q.pop_front()));
    endtask

    // IDLE -> REQ -> TURN -> DRIVE for u1 with grant held high.
    task automatic start_burst(input logic [7:0] d);
        drive(1, 1, d, 0, 1);
        tick(); tick(); tick();
        chk("burst_in_drive", 32'(st1), 32'(DRIVE));
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       r, v;
        logic [7:0] d;
        logic       l, g;
        logic       en;
        logic [7:0] i;
        logic       req, rdy, busy;
        state_t     st;
    } vec_t;

    vec_t tbl[10];

    initial begin : main
        logic [7:0] end_i;
        logic       g_r;
        end_i = PARK ? 8'h00 : 8'h3C;
        m1 = '{st: IDLE, elapsed: 5'd0, en: 1'b0, i: 8'h00, abort: 1'b0};
        m0 = m1;
        drive(0, 0, 8'h00, 0, 0);

        //           r     v     d      l     g     en    i      req   rdy   busy  st
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, IDLE};
        tbl[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, REQ};
        tbl[2] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, REQ};
        tbl[3] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, TURN};
        tbl[4] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, DRIVE};
        tbl[5] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, DRIVE};
        tbl[6] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, HOLD};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, REL};
        tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, end_i, 1'b0, 1'b0, 1'b0, IDLE};
        tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, end_i, 1'b0, 1'b0, 1'b0, IDLE};

        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].g);
            tick();
            chk($sformatf("tbl%0d_en", k),    32'(en1),   32'(tbl[k].en));
            chk($sformatf("tbl%0d_i", k),     32'(i1),    32'(tbl[k].i));
            chk($sformatf("tbl%0d_req", k),   32'(req1),  32'(tbl[k].req));
            chk($sformatf("tbl%0d_rdy", k),   32'(rdy1),  32'(tbl[k].rdy));
            chk($sformatf("tbl%0d_busy", k),  32'(busy1), 32'(tbl[k].busy));
            chk($sformatf("tbl%0d_state", k), 32'(st1),   32'(tbl[k].st));
        end

        // Bubble: three idle cycles mid-burst keep EN and the last word.
        start_burst(8'h5A);
        drive(1, 1, 8'h5A, 0, 1); tick();
        chk("bubble_first_word", 32'(i1), 32'h5A);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 8'hEE, 0, 1); tick();
            chk("bubble_en", 32'(en1), 32'd1);
            chk("bubble_i",  32'(i1),  32'h5A);
        end
        drive(1, 1, 8'hC3, 1, 1); tick();
        chk("bubble_last_i", 32'(i1), 32'hC3);
        drive(1, 0, 8'h00, 0, 1); tick(); tick();
        chk("bubble_end_idle", 32'(st1), 32'(IDLE));

        // Grant loss after 0x11; the queued 0x22 must survive to the next burst.
        start_burst(8'h11);
        drive(1, 1, 8'h11, 0, 1); tick();
        chk("gl_drive_i", 32'(i1), 32'h11);
        drive(1, 0, 8'h22, 0, 0); tick();
        chk("gl_state_rel", 32'(st1),    32'(REL));
        chk("gl_en_low",    32'(en1),    32'd0);
        chk("gl_rdy_low",   32'(rdy1),   32'd0);
        chk("gl_abort_set", 32'(abort1), 32'd1);
        drive(1, 1, 8'h22, 0, 0); tick();
        chk("gl_idle",      32'(st1), 32'(IDLE));
        chk("gl_idle_i",    32'(i1),  PARK ? 32'h00 : 32'h11);
        tick();
        chk("gl_rereq",     32'(st1),    32'(REQ));
        chk("gl_abort_clr", 32'(abort1), 32'd0);
        drive(1, 1, 8'h22, 1, 1); tick(); tick(); tick();
        chk("gl_queued_word", 32'(i1),  32'h22);
        chk("gl_queued_hold", 32'(st1), 32'(HOLD));
        drive(1, 0, 8'h00, 0, 1); tick(); tick();

        // Reset mid-DRIVE.
        start_burst(8'h77);
        drive(1, 1, 8'h77, 0, 1); tick();
        chk("rst_pre_en", 32'(en1), 32'd1);
        drive(0, 1, 8'h88, 0, 1); tick();
        chk("rst_en",    32'(en1),  32'd0);
        chk("rst_req",   32'(req1), 32'd0);
        chk("rst_i",     32'(i1),   32'h00);
        chk("rst_state", 32'(st1),  32'(IDLE));
        chk("rst_busy",  32'(busy1), 32'd0);
        drive(1, 0, 8'h00, 0, 0); tick();

        // Zero TURN/HOLD on u0, burst ending with 0xFF.
        drive(1, 1, 8'h3C, 0, 1); tick(); tick();
        chk("z_drive_at_gnt", 32'(st0), 32'(DRIVE));
        chk("z_en_before_hs", 32'(en0), 32'd0);
        tick();
        chk("z_en_after_hs",  32'(en0), 32'd1);
        chk("z_first_i",      32'(i0),  32'h3C);
        drive(1, 1, 8'hFF, 1, 1); tick();
        chk("z_last_on_bus",  32'(i0),  32'hFF);
        chk("z_last_en",      32'(en0), 32'd1);
        drive(1, 0, 8'h00, 0, 1); tick();
        chk("z_en_fall",      32'(en0),  32'd0);
        chk("z_req_fall",     32'(req0), 32'd0);
        chk("z_park_i",       32'(i0),   PARK ? 32'h00 : 32'hFF);

        // Random traffic against the models.
        drive(0, 0, 8'h00, 0, 0); tick();
        g_r = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (g_r) g_r = ($urandom_range(0, 24) != 0);
            else     g_r = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), ($urandom_range(0, 3) == 0), g_r);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
